// File: rtl/div_seq_64_pkg.sv
// Shared divider definitions: datapath width, iteration count, counter width
// and the FSM state encoding used by the sequential 64-bit divider.
package div_seq_64_pkg;

  localparam int unsigned WIDTH = 64;
  localparam int unsigned ITER  = 64;
  localparam int unsigned CNT_W = 7;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    BUSY = 2'd1,
    DONE = 2'd2
  } state_t;

endpackage

// File: rtl/Adder_Sub_64.sv
// 64-bit adder/subtractor. carryin=1 selects subtract (a + ~b + 1); with
// carryin=0 it adds. carryout=1 in subtract mode means a >= b (no borrow).
// Ports:
//   a, b      : operands
//   carryin   : 1 = subtract, 0 = add (also the carry into bit 0)
//   sum       : result
//   carryout  : carry out of bit WIDTH-1
module Adder_Sub_64
  import div_seq_64_pkg::*;
(
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  input  logic             carryin,
  output logic [WIDTH-1:0] sum,
  output logic             carryout
);

  logic [WIDTH-1:0] b_eff;

  // Invert b in subtract mode; carryin supplies the +1 of two's complement.
  assign b_eff = b ^ {WIDTH{carryin}};
  assign {carryout, sum} = {1'b0, a} + {1'b0, b_eff} + (WIDTH + 1)'(carryin);

endmodule

// File: rtl/div_seq_64.sv
// Sequential restoring divider, one quotient bit per cycle.
// A start accepted in IDLE or DONE captures the operands; a nonzero divisor
// runs 64 BUSY iterations, a zero divisor jumps straight to DONE with the
// divide-by-zero result. done pulses for one cycle with results valid.
// Ports:
//   clk, reset            : clock, asynchronous active-high reset
//   start                 : request a division (ignored while busy)
//   dividend, divisor     : unsigned operands, captured on accepted start
//   busy                  : high while iterating
//   done                  : one-cycle completion pulse
//   quotient, remainder   : registered results of the last completed operation
//   div_by_zero           : registered flag of the last completed operation
module div_seq_64 #(
  parameter int unsigned WIDTH = div_seq_64_pkg::WIDTH
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             start,
  input  logic [WIDTH-1:0] dividend,
  input  logic [WIDTH-1:0] divisor,
  output logic             busy,
  output logic             done,
  output logic [WIDTH-1:0] quotient,
  output logic [WIDTH-1:0] remainder,
  output logic             div_by_zero
);

  import div_seq_64_pkg::*;

  state_t state;
  state_t state_nxt;

  logic [WIDTH-1:0] r_reg;
  logic [WIDTH-1:0] q_reg;
  logic [WIDTH-1:0] d_reg;
  logic [CNT_W-1:0] cnt;

  logic             msb;
  logic [WIDTH-1:0] r_sh;
  logic [WIDTH-1:0] diff;
  logic             carry;
  logic             accept;
  logic [WIDTH-1:0] r_new;
  logic [WIDTH-1:0] q_new;
  logic             last;
  logic             start_ok;
  logic             zero_div;

  logic             busy_nxt;
  logic             done_nxt;
  logic             load_dbz;
  logic             load_res;

  // Start is only honoured outside BUSY.
  assign start_ok = start && (state != BUSY);
  assign zero_div = (divisor == '0);

  // Shift {msb, R, Q} left by one; msb is the bit that falls out of R.
  assign msb  = r_reg[WIDTH-1];
  assign r_sh = {r_reg[WIDTH-2:0], q_reg[WIDTH-1]};

  Adder_Sub_64 u_sub (
    .a        (r_sh),
    .b        (d_reg),
    .carryin  (1'b1),
    .sum      (diff),
    .carryout (carry)
  );

  // The 65-bit shifted remainder fits the divisor if msb is set or no borrow.
  assign accept = msb | carry;
  assign r_new  = accept ? diff : r_sh;
  assign q_new  = {q_reg[WIDTH-2:0], accept};
  assign last   = (cnt == CNT_W'(ITER - 1));

  // State register.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state <= IDLE;
    end else begin
      state <= state_nxt;
    end
  end

  // Next-state logic.
  always_comb begin
    state_nxt = state;
    case (state)
      IDLE, DONE: begin
        if (start) begin
          state_nxt = zero_div ? DONE : BUSY;
        end else begin
          state_nxt = IDLE;
        end
      end
      BUSY: begin
        if (last) begin
          state_nxt = DONE;
        end
      end
      default: state_nxt = IDLE;
    endcase
  end

  // Output/control decode; feeds the registered outputs below.
  always_comb begin
    busy_nxt = 1'b0;
    done_nxt = 1'b0;
    load_dbz = 1'b0;
    load_res = 1'b0;
    busy_nxt = (state_nxt == BUSY);
    done_nxt = (state_nxt == DONE);
    load_dbz = start_ok && zero_div;
    load_res = (state == BUSY) && last;
  end

  // Working registers, counter and result registers.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      busy        <= 1'b0;
      done        <= 1'b0;
      quotient    <= '0;
      remainder   <= '0;
      div_by_zero <= 1'b0;
      r_reg       <= '0;
      q_reg       <= '0;
      d_reg       <= '0;
      cnt         <= '0;
    end else begin
      busy <= busy_nxt;
      done <= done_nxt;

      if (start_ok) begin
        d_reg <= divisor;
        q_reg <= dividend;
        r_reg <= '0;
        cnt   <= '0;
      end else if (state == BUSY) begin
        r_reg <= r_new;
        q_reg <= q_new;
        cnt   <= cnt + CNT_W'(1);
      end

      if (load_dbz) begin
        quotient    <= '1;
        remainder   <= dividend;
        div_by_zero <= 1'b1;
      end else if (load_res) begin
        quotient    <= q_new;
        remainder   <= r_new;
        div_by_zero <= 1'b0;
      end
    end
  end

endmodule

// File: tb/tb_div_seq_64.sv
// Self-checking bench for div_seq_64: directed corner cases plus random
// operands checked against plain '/' and '%' arithmetic.
module tb_div_seq_64;

  logic        clk;
  logic        reset;
  logic        start;
  logic [63:0] dividend;
  logic [63:0] divisor;
  logic        busy;
  logic        done;
  logic [63:0] quotient;
  logic [63:0] remainder;
  logic        div_by_zero;

  int tests;
  int fails;

  div_seq_64 #(.WIDTH(64)) dut (
    .clk         (clk),
    .reset       (reset),
    .start       (start),
    .dividend    (dividend),
    .divisor     (divisor),
    .busy        (busy),
    .done        (done),
    .quotient    (quotient),
    .remainder   (remainder),
    .div_by_zero (div_by_zero)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    tests++;
    assert (obs === exp)
    else begin
      fails++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  function automatic logic [63:0] rnd64();
    return {$urandom(), $urandom()};
  endfunction

  // Issue one operation and check latency, results and the single-cycle done.
  task automatic run_op(input string tag, input logic [63:0] a, input logic [63:0] b);
    logic [63:0] eq;
    logic [63:0] er;
    int          exp_lat;
    int          lat;
    bit          seen;
    eq      = (b == 64'd0) ? 64'hFFFF_FFFF_FFFF_FFFF : a / b;
    er      = (b == 64'd0) ? a : a % b;
    exp_lat = (b == 64'd0) ? 1 : 65;
    dividend = a;
    divisor  = b;
    start    = 1'b1;
    seen     = 1'b0;
    lat      = -1;
    for (int i = 1; i <= 200 && !seen; i++) begin
      tick();
      if (i == 1) begin
        start    = 1'b0;
        dividend = rnd64();
        divisor  = rnd64();
        check({tag, "_busy"}, 64'(busy), (b == 64'd0) ? 64'd0 : 64'd1);
      end
      if (done) begin
        seen = 1'b1;
        lat  = i;
      end
    end
    check({tag, "_latency"}, 64'(lat), 64'(exp_lat));
    check({tag, "_quotient"}, quotient, eq);
    check({tag, "_remainder"}, remainder, er);
    check({tag, "_dbz"}, 64'(div_by_zero), (b == 64'd0) ? 64'd1 : 64'd0);
    tick();
    check({tag, "_done_pulse"}, 64'(done), 64'd0);
    check({tag, "_hold_q"}, quotient, eq);
  endtask

  initial begin
    int          lat;
    bit          seen;
    logic [63:0] a;
    logic [63:0] b;

    tests    = 0;
    fails    = 0;
    reset    = 1'b1;
    start    = 1'b0;
    dividend = '0;
    divisor  = '0;
    tick();
    tick();
    check("rst_busy", 64'(busy), 64'd0);
    check("rst_done", 64'(done), 64'd0);
    check("rst_quotient", quotient, 64'd0);
    check("rst_remainder", remainder, 64'd0);
    check("rst_dbz", 64'(div_by_zero), 64'd0);
    reset = 1'b0;
    tick();

    run_op("d100_7", 64'd100, 64'd7);
    run_op("d5_0", 64'd5, 64'd0);
    run_op("allones_1", 64'hFFFF_FFFF_FFFF_FFFF, 64'd1);
    run_op("allones_allones", 64'hFFFF_FFFF_FFFF_FFFF, 64'hFFFF_FFFF_FFFF_FFFF);
    run_op("small_big", 64'd7, 64'd100);

    // Start re-pulsed mid-operation must be ignored.
    dividend = 64'd3;
    divisor  = 64'h8000_0000_0000_0000;
    start    = 1'b1;
    seen     = 1'b0;
    lat      = -1;
    for (int i = 1; i <= 200 && !seen; i++) begin
      tick();
      if (i == 1) begin
        start = 1'b0;
      end
      if (i == 9) begin
        start    = 1'b1;
        dividend = 64'd100;
        divisor  = 64'd7;
      end
      if (i == 10) begin
        start = 1'b0;
        check("ignore_busy", 64'(busy), 64'd1);
      end
      if (done) begin
        seen = 1'b1;
        lat  = i;
      end
    end
    check("ignore_latency", 64'(lat), 64'd65);
    check("ignore_quotient", quotient, 64'd0);
    check("ignore_remainder", remainder, 64'd3);
    tick();

    // Reset in the middle of an operation.
    dividend = 64'd1000;
    divisor  = 64'd9;
    start    = 1'b1;
    for (int i = 1; i <= 30; i++) begin
      tick();
      if (i == 1) begin
        start = 1'b0;
      end
    end
    reset = 1'b1;
    #1;
    check("midrst_busy", 64'(busy), 64'd0);
    check("midrst_done", 64'(done), 64'd0);
    check("midrst_quotient", quotient, 64'd0);
    check("midrst_remainder", remainder, 64'd0);
    check("midrst_dbz", 64'(div_by_zero), 64'd0);
    tick();
    reset = 1'b0;
    seen  = 1'b0;
    for (int i = 0; i < 70; i++) begin
      tick();
      if (done || busy) begin
        seen = 1'b1;
      end
    end
    check("midrst_no_done", 64'(seen), 64'd0);
    run_op("d9_3", 64'd9, 64'd3);

    // Start held high through DONE: back-to-back operations.
    dividend = 64'd100;
    divisor  = 64'd7;
    start    = 1'b1;
    seen     = 1'b0;
    lat      = -1;
    for (int i = 1; i <= 200 && !seen; i++) begin
      tick();
      if (i == 1) begin
        dividend = 64'd1000;
        divisor  = 64'd9;
      end
      if (done) begin
        seen = 1'b1;
        lat  = i;
      end
    end
    check("held_lat1", 64'(lat), 64'd65);
    check("held_q1", quotient, 64'd14);
    check("held_r1", remainder, 64'd2);
    tick();
    start = 1'b0;
    check("held_accept_busy", 64'(busy), 64'd1);
    check("held_accept_done", 64'(done), 64'd0);
    seen = 1'b0;
    lat  = -1;
    for (int i = 2; i <= 200 && !seen; i++) begin
      tick();
      if (done) begin
        seen = 1'b1;
        lat  = i;
      end
    end
    check("held_lat2", 64'(lat), 64'd65);
    check("held_q2", quotient, 64'd111);
    check("held_r2", remainder, 64'd1);
    tick();

    // Random operands.
    for (int n = 0; n < 24; n++) begin
      a = rnd64();
      case ($urandom_range(0, 7))
        0:       b = 64'd0;
        1, 2:    b = 64'($urandom_range(1, 1000));
        3, 4:    b = rnd64() >> $urandom_range(0, 63);
        default: b = rnd64();
      endcase
      if ($urandom_range(0, 3) == 0) begin
        a = a >> $urandom_range(0, 63);
      end
      run_op($sformatf("rand%0d", n), a, b);
    end

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule

// File: doc/div_seq_64.md
DIV_SEQ_64 -- requirements
Module: div_seq_64

Interface
REQ-001 SHALL have parameter WIDTH, default 64, operand width; only 64 is supported.
REQ-002 SHALL have port clk  input  1  single clock; all state updates on rising edge.
REQ-003 SHALL have port reset  input  1  asynchronous, active-high reset.
REQ-004 SHALL have port start  input  1  request a new division; sampled only when busy=0.
REQ-005 SHALL have port dividend  input  64  unsigned dividend; captured when start is accepted.
REQ-006 SHALL have port divisor  input  64  unsigned divisor; captured when start is accepted.
REQ-007 SHALL have port busy  output  1  high while iterating (state BUSY).
REQ-008 SHALL have port done  output  1  one-cycle pulse; result registers valid from this cycle.
REQ-009 SHALL have port quotient  output  64  registered quotient result.
REQ-010 SHALL have port remainder  output  64  registered remainder result.
REQ-011 SHALL have port div_by_zero  output  1  registered flag for the last completed operation.

Function
REQ-012 SHALL implement an FSM with states IDLE, BUSY and DONE; reset state is IDLE.
REQ-013 SHALL accept start in IDLE or DONE, capturing operands, clearing working remainder R and count, and loading working quotient Q with the dividend.
REQ-014 SHALL go from IDLE/DONE to BUSY on accepted start with divisor != 0, and directly to DONE on the next edge with divisor == 0.
REQ-015 SHALL perform restoring division, one bit per BUSY cycle:
- shift {msb, R, Q} left by one;
- compute diff = R_shifted - D on the shared subtractor (Carryin=1).
REQ-016 SHALL define accept = msb OR subtractor Carryout, and then:
- if accept: R <= diff and Q[0] <= 1;
- else: R <= R_shifted and Q[0] <= 0.
REQ-017 SHALL use a 7-bit iteration counter, leave BUSY after exactly 64 iterations, and enter DONE.
REQ-018 SHALL make done rise exactly 65 cycles after the accepted start edge for a nonzero divisor, and 1 cycle after for a zero divisor.
REQ-019 SHALL load quotient, remainder and div_by_zero on entry to DONE and hold them until the next DONE entry.
REQ-020 SHALL produce quotient = all ones, remainder = dividend and div_by_zero=1 on divide-by-zero.
REQ-021 SHALL ignore start while in BUSY; neither the operands nor the counter are disturbed.
REQ-022 SHALL return from DONE to IDLE after one cycle unless start is asserted; if start is asserted in DONE, it SHALL be accepted as in IDLE.
REQ-023 SHALL not use subtractor Overflow, Negative or Zero; Carryout alone, qualified with msb, determines accept.

Reset
REQ-024 SHALL, when reset is asserted in any state including mid-BUSY, enter IDLE immediately and abandon the operation without a done pulse.
REQ-025 SHALL drive, during reset: busy=0, done=0, quotient=0, remainder=0, div_by_zero=0, with working registers and counter cleared.

Structure
REQ-026 SHALL take state enum (IDLE, BUSY, DONE) and constants WIDTH=64 and ITER=64 from a shared divider package.
REQ-027 SHALL instantiate exactly one Adder_Sub_64 sub-module with Carryin tied to 1 (subtract mode); no other arithmetic operator is used on the 64-bit datapath.

Verification
REQ-028 SHALL verify: dividend=100, divisor=7, start pulse -> done at cycle 65, quotient=14, remainder=2, div_by_zero=0.
REQ-029 SHALL verify: dividend=5, divisor=0 -> done at cycle 1, quotient=64'hFFFF_FFFF_FFFF_FFFF, remainder=5, div_by_zero=1.
REQ-030 SHALL verify: dividend=64'hFFFF_FFFF_FFFF_FFFF, divisor=1 -> quotient=all ones, remainder=0 (exercises msb path).
REQ-031 SHALL verify: dividend=3, divisor=64'h8000_0000_0000_0000 -> quotient=0, remainder=3; start re-pulsed at cycle 10 is ignored.
REQ-032 SHALL verify: reset asserted at cycle 30 of an operation -> busy=0 and all outputs 0 immediately, no done pulse; a following 9/3 gives quotient=3, remainder=0.
REQ-033 SHALL verify: start held high through DONE -> second operation accepted in the DONE cycle, next done exactly 65 cycles later.
